fma_array: RTL and testbench

Parametrised, pipelined, signed fixed-point fused multiply-add array with `LANES` independent lanes sharing one valid/ready handshake. Each lane computes `a*b+c`, `a*b+acc`, `a*b`, or loads its accumulator, with optional round-to-nearest and saturation. It sits between the operand fetch logic and the result writeback path in the GPU compute datapath, and is the multi-lane successor of the single scalar FMA.

---
 rtl/fma_pkg.sv | 11 +
 rtl/fma_lane.sv | 90 +++++++++
 rtl/fma_array.sv | 79 +++++++
 tb/tb_fma_array.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fma_pkg.sv
// Shared types for the multi-lane fixed-point FMA array.
package fma_pkg;

  typedef enum logic [1:0] {
    FMA_MODE_FMA  = 2'd0,
    FMA_MODE_MAC  = 2'd1,
    FMA_MODE_MUL  = 2'd2,
    FMA_MODE_LOAD = 2'd3
  } fma_mode_t;

endpackage

// File: rtl/fma_lane.sv
// One lane: stage 1 product/addend register, stage 2 round/add/saturate, and
// the lane accumulator. The accumulator doubles as the lane output register
// because every completed beat writes the same value to both.
module fma_lane
  import fma_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int FIXED_POINT = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             update,
  input  fma_mode_t        mode,
  input  logic             round,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] result,
  output logic             sat
);

  localparam int PW = 2*WIDTH + 1;

  localparam logic signed [PW-1:0] HALF  =
    {{(PW-FIXED_POINT){1'b0}}, 1'b1, {(FIXED_POINT-1){1'b0}}};
  localparam logic signed [PW-1:0] MAX_V = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] MIN_V = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]          c_q;
  logic [WIDTH-1:0]          acc_q;
  logic                      sat_q;

  logic signed [PW-1:0]      rounded;
  logic signed [PW-1:0]      p;
  logic signed [PW-1:0]      sum;
  logic [WIDTH-1:0]          addend;
  logic [WIDTH-1:0]          nxt;
  logic                      nxt_sat;

  // Stage 1: capture the full-precision signed product and the addend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      c_q    <= '0;
    end else if (load) begin
      prod_q <= $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
      c_q    <= c;
    end
  end

  // Stage 2 combinational: round, rescale, add the selected addend, clamp.
  always_comb begin
    rounded = {prod_q[2*WIDTH-1], prod_q} + (round ? HALF : '0);
    p       = rounded >>> FIXED_POINT;
    case (mode)
      FMA_MODE_FMA: addend = c_q;
      FMA_MODE_MAC: addend = acc_q;
      default:      addend = '0;
    endcase
    sum     = p + {{(PW-WIDTH){addend[WIDTH-1]}}, addend};
    nxt     = sum[WIDTH-1:0];
    nxt_sat = 1'b0;
    if (mode == FMA_MODE_LOAD) begin
      nxt = c_q;
    end else if (sum > MAX_V) begin
      nxt     = MAX_V[WIDTH-1:0];
      nxt_sat = 1'b1;
    end else if (sum < MIN_V) begin
      nxt     = MIN_V[WIDTH-1:0];
      nxt_sat = 1'b1;
    end
  end

  // Stage 2 register: accumulator/output and saturation flag move only when a beat completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else if (update) begin
      acc_q <= nxt;
      sat_q <= nxt_sat;
    end
  end

  assign result = acc_q;
  assign sat    = sat_q;

endmodule

// File: rtl/fma_array.sv
// LANES-wide pipelined fixed-point FMA sharing one valid/ready handshake.
// The whole pipe advances as one unit whenever the output slot is free or
// being drained, so a single advance strobe gates every lane.
module fma_array
  import fma_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int FIXED_POINT = 10,
  parameter int LANES       = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic [LANES*WIDTH-1:0] a_in,
  input  logic [LANES*WIDTH-1:0] b_in,
  input  logic [LANES*WIDTH-1:0] c_in,
  input  logic [1:0]             mode_in,
  input  logic                   round_in,
  input  logic                   valid_in,
  output logic                   ready_out,
  output logic [LANES*WIDTH-1:0] out,
  output logic [LANES-1:0]       sat_out,
  output logic                   valid_out,
  input  logic                   ready_in
);

  logic      advance;
  logic      accept;
  logic      s1_valid;
  fma_mode_t s1_mode;
  logic      s1_round;

  assign advance   = !valid_out || ready_in;
  assign ready_out = advance;
  assign accept    = valid_in && advance;

  // Stage 1 control: beat valid plus the per-beat mode and rounding choice.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_valid <= 1'b0;
      s1_mode  <= FMA_MODE_FMA;
      s1_round <= 1'b0;
    end else if (advance) begin
      s1_valid <= valid_in;
      if (valid_in) begin
        s1_mode  <= fma_mode_t'(mode_in);
        s1_round <= round_in;
      end
    end
  end

  // Output valid follows stage 1 on every advance; holds while stalled.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_out <= 1'b0;
    end else if (advance) begin
      valid_out <= s1_valid;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fma_lane #(
      .WIDTH       (WIDTH),
      .FIXED_POINT (FIXED_POINT)
    ) u_lane (
      .clk    (clk_in),
      .rst_n  (rst_n_in),
      .load   (accept),
      .update (advance && s1_valid),
      .mode   (s1_mode),
      .round  (s1_round),
      .a      (a_in[i*WIDTH +: WIDTH]),
      .b      (b_in[i*WIDTH +: WIDTH]),
      .c      (c_in[i*WIDTH +: WIDTH]),
      .result (out[i*WIDTH +: WIDTH]),
      .sat    (sat_out[i])
    );
  end

endmodule

// File: tb/tb_fma_array.sv
// Self-checking bench for fma_array: directed test-plan cases plus a
// randomized backpressure stream checked against an arithmetic lane model.
module tb_fma_array;

  localparam int W  = 16;
  localparam int FP = 10;
  localparam int L  = 4;

  typedef struct {
    logic [1:0]     mode;
    logic           rnd;
    logic [L*W-1:0] a;
    logic [L*W-1:0] b;
    logic [L*W-1:0] c;
  } beat_t;

  logic           clk_in = 1'b0;
  logic           rst_n_in = 1'b0;
  logic [L*W-1:0] a_in = '0;
  logic [L*W-1:0] b_in = '0;
  logic [L*W-1:0] c_in = '0;
  logic [1:0]     mode_in = '0;
  logic           round_in = 1'b0;
  logic           valid_in = 1'b0;
  logic           ready_out;
  logic [L*W-1:0] out;
  logic [L-1:0]   sat_out;
  logic           valid_out;
  logic           ready_in = 1'b1;

  int checks = 0;
  int errors = 0;
  longint m_acc [L];

  fma_array #(.WIDTH(W), .FIXED_POINT(FP), .LANES(L)) dut (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .a_in      (a_in),
    .b_in      (b_in),
    .c_in      (c_in),
    .mode_in   (mode_in),
    .round_in  (round_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .out       (out),
    .sat_out   (sat_out),
    .valid_out (valid_out),
    .ready_in  (ready_in)
  );

  always #5 clk_in = ~clk_in;

  // Reference: real-valued product scaled by 2^FP, floor after optional +0.5 LSB, then clamp.
  function automatic void model(input beat_t bt, output logic [L*W-1:0] eo, output logic [L-1:0] es);
    logic signed [W-1:0] ta, tb, tc;
    longint av, bv, cv, p, s, lim_hi, lim_lo;
    lim_hi = (longint'(1) << (W-1)) - 1;
    lim_lo = -(longint'(1) << (W-1));
    eo = '0;
    es = '0;
    for (int i = 0; i < L; i++) begin
      ta = bt.a[i*W +: W];
      tb = bt.b[i*W +: W];
      tc = bt.c[i*W +: W];
      av = ta; bv = tb; cv = tc;
      if (bt.mode == 2'd3) begin
        s = cv;
      end else begin
        p = av * bv;
        if (bt.rnd) p = p + (longint'(1) << (FP-1));
        p = p >>> FP;
        case (bt.mode)
          2'd0:    s = p + cv;
          2'd1:    s = p + m_acc[i];
          default: s = p;
        endcase
        if (s > lim_hi) begin s = lim_hi; es[i] = 1'b1; end
        if (s < lim_lo) begin s = lim_lo; es[i] = 1'b1; end
      end
      m_acc[i] = s;
      eo[i*W +: W] = s[W-1:0];
    end
  endfunction

  function automatic beat_t rand_beat(input logic [1:0] m, input logic r);
    beat_t bt;
    bt.mode = m;
    bt.rnd  = r;
    bt.a = {$urandom, $urandom};
    bt.b = {$urandom, $urandom};
    bt.c = {$urandom, $urandom};
    // Bias some operands toward small magnitudes so not every lane saturates.
    for (int i = 0; i < L; i++) begin
      if ($urandom_range(0, 1) == 1) bt.a[i*W +: W] = W'($signed(12'($urandom)));
      if ($urandom_range(0, 1) == 1) bt.b[i*W +: W] = W'($signed(12'($urandom)));
    end
    return bt;
  endfunction

  task automatic drive(input beat_t bt);
    a_in = bt.a; b_in = bt.b; c_in = bt.c;
    mode_in = bt.mode; round_in = bt.rnd;
  endtask

  // Single isolated beat with ready_in=1; called at posedge+1 with an idle pipe.
  task automatic do_beat(input beat_t bt, output logic [L*W-1:0] o, output logic [L-1:0] s,
                         output int lat, output logic rdy);
    drive(bt);
    valid_in = 1'b1;
    rdy = ready_out;
    @(posedge clk_in); #1;
    valid_in = 1'b0;
    lat = 1;
    while (!valid_out && lat < 10) begin
      @(posedge clk_in); #1;
      lat++;
    end
    o = out;
    s = sat_out;
    @(posedge clk_in); #1;
  endtask

  task automatic test_reset();
    #23 rst_n_in = 1'b1;
    #1;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_out); end
    checks++; if (out !== '0) begin errors++; $display("FAIL reset_out got %h want 0", out); end
    checks++; if (sat_out !== '0) begin errors++; $display("FAIL reset_sat got %b want 0", sat_out); end
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready_out); end
    for (int i = 0; i < L; i++) m_acc[i] = 0;
    @(posedge clk_in); #1;
  endtask

  task automatic test_fma();
    beat_t bt; logic [L*W-1:0] o, eo; logic [L-1:0] s, es; int lat; logic rdy;
    bt = rand_beat(2'd0, 1'b0);
    bt.a[15:0] = 16'h0600; bt.b[15:0] = 16'h0800; bt.c[15:0] = 16'h0200;
    model(bt, eo, es);
    do_beat(bt, o, s, lat, rdy);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL fma_ready got %b want 1", rdy); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL fma_latency got %0d want 2", lat); end
    checks++; if (o[15:0] !== 16'h0E00) begin errors++; $display("FAIL fma_lane0 got %h want 0e00", o[15:0]); end
    checks++; if (s[0] !== 1'b0) begin errors++; $display("FAIL fma_sat0 got %b want 0", s[0]); end
    checks++; if (o !== eo || s !== es) begin errors++; $display("FAIL fma_all got %h/%b want %h/%b", o, s, eo, es); end
  endtask

  task automatic test_mac_chain();
    beat_t bt; beat_t mb [3]; logic [L*W-1:0] o, eo; logic [L-1:0] s, es; int lat; logic rdy;
    logic [L*W-1:0] exp_o [3]; logic [L-1:0] exp_s [3];
    logic [L*W-1:0] got_o [3]; logic [L-1:0] got_s [3];
    int k, got, cyc, acc_cycles;
    bt = rand_beat(2'd3, 1'b0);
    bt.c[15:0] = 16'h0000;
    model(bt, eo, es);
    do_beat(bt, o, s, lat, rdy);
    checks++; if (o !== eo || s !== es) begin errors++; $display("FAIL load got %h/%b want %h/%b", o, s, eo, es); end
    for (int j = 0; j < 3; j++) begin
      mb[j] = rand_beat(2'd1, 1'(j));
      mb[j].a[15:0] = 16'h0400; mb[j].b[15:0] = 16'h0400;
    end
    k = 0; got = 0; cyc = 0; acc_cycles = 0;
    ready_in = 1'b1;
    while (got < 3 && cyc < 20) begin
      valid_in = (k < 3);
      if (k < 3) drive(mb[k]);
      @(negedge clk_in);
      if (valid_out) begin got_o[got] = out; got_s[got] = sat_out; got++; end
      if (valid_in && ready_out) begin model(mb[k], exp_o[k], exp_s[k]); k++; acc_cycles++; end
      @(posedge clk_in); #1;
      cyc++;
    end
    valid_in = 1'b0;
    checks++; if (got !== 3) begin errors++; $display("FAIL mac_count got %0d want 3", got); end
    checks++; if (cyc !== 5) begin errors++; $display("FAIL mac_b2b_cycles got %0d want 5", cyc); end
    for (int j = 0; j < 3 && j < got; j++) begin
      checks++;
      if (got_o[j][15:0] !== 16'(16'h0400 * (j+1))) begin
        errors++; $display("FAIL mac_lane0_%0d got %h want %h", j, got_o[j][15:0], 16'(16'h0400 * (j+1)));
      end
      checks++;
      if (got_o[j] !== exp_o[j] || got_s[j] !== exp_s[j]) begin
        errors++; $display("FAIL mac_all_%0d got %h/%b want %h/%b", j, got_o[j], got_s[j], exp_o[j], exp_s[j]);
      end
    end
    @(posedge clk_in); #1;
  endtask

  task automatic test_sign_sat();
    logic [15:0] va [3] = '{16'hFC00, 16'h2000, 16'h8000};
    logic [15:0] vb [3] = '{16'h0800, 16'h2000, 16'h8000};
    logic [15:0] vr [3] = '{16'hF800, 16'h7FFF, 16'h7FFF};
    logic        vs [3] = '{1'b0, 1'b1, 1'b1};
    beat_t bt; logic [L*W-1:0] o, eo; logic [L-1:0] s, es; int lat; logic rdy;
    for (int j = 0; j < 3; j++) begin
      bt = rand_beat(2'd2, 1'b0);
      bt.a[15:0] = va[j]; bt.b[15:0] = vb[j];
      model(bt, eo, es);
      do_beat(bt, o, s, lat, rdy);
      checks++; if (o[15:0] !== vr[j] || s[0] !== vs[j]) begin
        errors++; $display("FAIL sign_sat_%0d got %h/%b want %h/%b", j, o[15:0], s[0], vr[j], vs[j]);
      end
      checks++; if (o !== eo || s !== es) begin
        errors++; $display("FAIL sign_sat_all_%0d got %h/%b want %h/%b", j, o, s, eo, es);
      end
    end
  endtask

  task automatic test_rounding();
    beat_t bt; logic [L*W-1:0] o, eo; logic [L-1:0] s, es; int lat; logic rdy;
    for (int r = 0; r < 2; r++) begin
      bt = rand_beat(2'd2, 1'(r));
      bt.a[15:0] = 16'h0001; bt.b[15:0] = 16'h0200; bt.c[15:0] = 16'h0000;
      model(bt, eo, es);
      do_beat(bt, o, s, lat, rdy);
      checks++; if (o[15:0] !== 16'(r)) begin
        errors++; $display("FAIL round_%0d got %h want %h", r, o[15:0], 16'(r));
      end
      checks++; if (o !== eo || s !== es) begin
        errors++; $display("FAIL round_all_%0d got %h/%b want %h/%b", r, o, s, eo, es);
      end
    end
  endtask

  task automatic test_backpressure();
    localparam int N = 12;
    logic [L*W+L-1:0] q [$];
    logic [L*W+L-1:0] e;
    logic [L*W-1:0] eo, prev_o;
    logic [L-1:0] es, prev_s;
    beat_t cur;
    logic pending, prev_stall;
    int sent, recv, cyc, bad_rdy, bad_stall, bad_data;
    sent = 0; recv = 0; cyc = 0; pending = 0; prev_stall = 0;
    bad_rdy = 0; bad_stall = 0; bad_data = 0;
    prev_o = '0; prev_s = '0;
    while ((sent < N || recv < N) && cyc < 400) begin
      if (!pending && sent < N && $urandom_range(0, 3) != 0) begin
        cur = rand_beat(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        pending = 1;
      end
      if (pending) drive(cur);
      valid_in = pending;
      ready_in = 1'($urandom_range(0, 1));
      @(negedge clk_in);
      if (ready_out !== !(valid_out && !ready_in)) begin
        bad_rdy++; $display("FAIL bp_ready cyc %0d got %b want %b", cyc, ready_out, !(valid_out && !ready_in));
      end
      if (prev_stall && (valid_out !== 1'b1 || out !== prev_o || sat_out !== prev_s)) begin
        bad_stall++; $display("FAIL bp_stall cyc %0d got %b/%h want 1/%h", cyc, valid_out, out, prev_o);
      end
      if (valid_out && ready_in) begin
        if (q.size() == 0) begin
          bad_data++; $display("FAIL bp_dup cyc %0d got %h want none", cyc, out);
        end else begin
          e = q.pop_front();
          if ({sat_out, out} !== e) begin
            bad_data++; $display("FAIL bp_data beat %0d got %h want %h", recv, {sat_out, out}, e);
          end
        end
        recv++;
      end
      if (valid_in && ready_out) begin
        model(cur, eo, es);
        q.push_back({es, eo});
        sent++;
        pending = 0;
      end
      prev_stall = valid_out && !ready_in;
      prev_o = out; prev_s = sat_out;
      @(posedge clk_in); #1;
      cyc++;
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    checks++; if (recv !== N) begin errors++; $display("FAIL bp_count got %0d want %0d", recv, N); end
    checks++; if (q.size() !== 0) begin errors++; $display("FAIL bp_leftover got %0d want 0", q.size()); end
    checks++; if (bad_rdy !== 0) begin errors++; $display("FAIL bp_ready_total got %0d want 0", bad_rdy); end
    checks++; if (bad_stall !== 0) begin errors++; $display("FAIL bp_stall_total got %0d want 0", bad_stall); end
    checks++; if (bad_data !== 0) begin errors++; $display("FAIL bp_data_total got %0d want 0", bad_data); end
    repeat (3) @(posedge clk_in);
    #1;
  endtask

  task automatic test_async_reset();
    beat_t bt; logic [L*W-1:0] o, eo; logic [L-1:0] s, es; int lat; logic rdy;
    ready_in = 1'b1;
    for (int j = 0; j < 3; j++) begin
      bt = rand_beat(2'd1, 1'b0);
      bt.a[15:0] = 16'h0400; bt.b[15:0] = 16'h0400;
      drive(bt);
      valid_in = 1'b1;
      @(posedge clk_in); #1;
    end
    #2 rst_n_in = 1'b0;
    valid_in = 1'b0;
    #1;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL arst_valid got %b want 0", valid_out); end
    checks++; if (out !== '0 || sat_out !== '0) begin errors++; $display("FAIL arst_out got %h/%b want 0/0", out, sat_out); end
    #13 rst_n_in = 1'b1;
    for (int i = 0; i < L; i++) m_acc[i] = 0;
    repeat (3) @(posedge clk_in);
    #1;
    checks++; if (valid_out !== 1'b0 || out !== '0) begin
      errors++; $display("FAIL arst_no_partial got %b/%h want 0/0", valid_out, out);
    end
    bt = rand_beat(2'd1, 1'b0);
    bt.a[15:0] = 16'h0400; bt.b[15:0] = 16'h0400;
    model(bt, eo, es);
    do_beat(bt, o, s, lat, rdy);
    checks++; if (o[15:0] !== 16'h0400) begin errors++; $display("FAIL arst_mac got %h want 0400", o[15:0]); end
    checks++; if (o !== eo || s !== es) begin errors++; $display("FAIL arst_mac_all got %h/%b want %h/%b", o, s, eo, es); end
  endtask

  initial begin
    test_reset();
    test_fma();
    test_mac_chain();
    test_sign_sat();
    test_rounding();
    test_backpressure();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
